// File: rtl/acq_sequencer.sv
// acq_sequencer: one DiscReader acquisition (arm, optional index wait, capture N revs, flush); byte->RAM write latency 1 cycle.
// No backpressure: bytes after RAM full are dropped. ACQ_TIMEOUT_EN builds the ARM index timeout.
module acq_sequencer #(
  parameter int ADDR_WIDTH   = 19,
  parameter int FLUSH_CLKS   = 3,
  parameter int TIMEOUT_CLKS = 50000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_wait_index,
  input  logic [7:0]            i_revs,
  input  logic                  i_addr_clr,
  input  logic                  i_index_in,
  input  logic [7:0]            i_rd_data,
  input  logic                  i_rd_write,
  output logic                  o_rd_run,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]            o_mem_data,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH:0]   o_byte_count,
  output logic                  o_busy,
  output logic                  o_waiting,
  output logic                  o_done,
  output logic                  o_mem_full,
  output logic                  o_no_index
);

  localparam int FW = (FLUSH_CLKS > 1) ? $clog2(FLUSH_CLKS) : 1;
  localparam logic [ADDR_WIDTH:0] LAST_COUNT = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_FLUSH} state_t;

  state_t                r_state, w_next;
  logic                  r_idx_prev, r_rd_run, r_mem_we, r_done, r_mem_full, r_no_index;
  logic [7:0]            r_revs, r_rev_cnt, r_mem_data;
  logic [ADDR_WIDTH-1:0] r_ptr, r_mem_addr;
  logic [ADDR_WIDTH:0]   r_byte_count;
  logic [FW-1:0]         r_flush_cnt;
  logic                  w_idx_edge, w_accept, w_last_write, w_start, w_clr, w_tmo;
  logic                  w_set_done, w_set_no_index;
  logic [7:0]            w_rev_inc;

  assign w_idx_edge   = i_index_in & ~r_idx_prev;
  assign w_accept     = i_rd_write & ~r_mem_full & ((r_state == S_CAPTURE) || (r_state == S_FLUSH));
  assign w_last_write = w_accept & (r_byte_count == LAST_COUNT);
  assign w_start      = i_start & (r_state == S_IDLE);
  assign w_clr        = i_addr_clr & (r_state == S_IDLE);
  assign w_rev_inc    = r_rev_cnt + 8'd1;

`ifdef ACQ_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)               r_tmo_cnt <= '0;
    else if (r_state != S_ARM) r_tmo_cnt <= '0;
    else                       r_tmo_cnt <= r_tmo_cnt + 32'd1;
  end

  assign w_tmo = (r_tmo_cnt == 32'(TIMEOUT_CLKS - 1));
`else
  // No timer built: ARM waits for an index edge or ABORT indefinitely.
  assign w_tmo = 1'b0 & (TIMEOUT_CLKS == 0);
`endif

  always_comb begin
    w_next         = r_state;
    w_set_done     = 1'b0;
    w_set_no_index = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          // A pending ADDR_CLR empties the RAM before the full check.
          if (r_mem_full & ~i_addr_clr) w_next = S_FLUSH;
          else if (i_wait_index)        w_next = S_ARM;
          else                          w_next = S_CAPTURE;
        end
      end
      S_ARM: begin
        if (i_abort)         w_next = S_IDLE;
        else if (w_idx_edge) w_next = S_CAPTURE;
        else if (w_tmo) begin
          w_next         = S_IDLE;
          w_set_no_index = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (i_abort)           w_next = S_IDLE;
        else if (w_last_write) w_next = S_FLUSH;
        else if (w_idx_edge && (r_revs != 8'd0) && (w_rev_inc == r_revs)) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (i_abort) w_next = S_IDLE;
        else if (r_flush_cnt == FW'(FLUSH_CLKS - 1)) begin
          w_next     = S_IDLE;
          w_set_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_idx_prev   <= 1'b0;
      r_rd_run     <= 1'b0;
      r_flush_cnt  <= '0;
      r_revs       <= '0;
      r_rev_cnt    <= '0;
      r_done       <= 1'b0;
      r_no_index   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_ptr        <= '0;
      r_byte_count <= '0;
      r_mem_full   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_idx_prev  <= i_index_in;
      r_rd_run    <= (w_next == S_CAPTURE);
      r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + FW'(1) : '0;

      if (w_start) begin
        r_revs     <= i_revs;
        r_rev_cnt  <= '0;
        r_done     <= 1'b0;
        r_no_index <= 1'b0;
      end else if ((r_state == S_CAPTURE) && w_idx_edge) begin
        r_rev_cnt <= w_rev_inc;
      end
      if (w_set_done)     r_done     <= 1'b1;
      if (w_set_no_index) r_no_index <= 1'b1;

      r_mem_we <= w_accept;
      if (w_clr) begin
        r_ptr        <= '0;
        r_byte_count <= '0;
        r_mem_full   <= 1'b0;
      end else if (w_accept) begin
        r_mem_addr   <= r_ptr;
        r_mem_data   <= i_rd_data;
        r_byte_count <= r_byte_count + 1'b1;
        // Pointer parks on the last address instead of wrapping.
        if (w_last_write) r_mem_full <= 1'b1;
        else              r_ptr      <= r_ptr + 1'b1;
      end
    end
  end

  assign o_rd_run     = r_rd_run & ~i_abort;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_data   = r_mem_data;
  assign o_mem_we     = r_mem_we;
  assign o_byte_count = r_byte_count;
  assign o_busy       = (r_state != S_IDLE);
  assign o_waiting    = (r_state == S_ARM);
  assign o_done       = r_done;
  assign o_mem_full   = r_mem_full;
  assign o_no_index   = r_no_index;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed table-driven bench for acq_sequencer (ADDR_WIDTH=4, FLUSH_CLKS=3, TIMEOUT_CLKS=10).
module tb_acq_sequencer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start, i_abort, i_wait_index, i_addr_clr, i_index_in, i_rd_write;
  logic [7:0]    i_revs, i_rd_data;
  logic          o_rd_run, o_mem_we, o_busy, o_waiting, o_done, o_mem_full, o_no_index;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    o_mem_data;
  logic [AW:0]   o_byte_count;

  always #5 clk = ~clk;

  acq_sequencer #(.ADDR_WIDTH(AW), .FLUSH_CLKS(3), .TIMEOUT_CLKS(10)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(i_start), .i_abort(i_abort),
    .i_wait_index(i_wait_index), .i_revs(i_revs), .i_addr_clr(i_addr_clr),
    .i_index_in(i_index_in), .i_rd_data(i_rd_data), .i_rd_write(i_rd_write),
    .o_rd_run(o_rd_run), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_we(o_mem_we), .o_byte_count(o_byte_count), .o_busy(o_busy),
    .o_waiting(o_waiting), .o_done(o_done), .o_mem_full(o_mem_full),
    .o_no_index(o_no_index)
  );

  // {run, we, addr, data, count, busy, waiting, done, full}
  wire [22:0] obs = {o_rd_run, o_mem_we, o_mem_addr, o_mem_data, o_byte_count,
                     o_busy, o_waiting, o_done, o_mem_full};

  typedef struct {
    logic       st, ab, wi;
    logic [7:0] revs;
    logic       clr, idx;
    logic [7:0] dat;
    logic       wr;
    logic [22:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [22:0] ex(input logic run, input logic we, input logic [3:0] a,
                                     input logic [7:0] d, input logic [4:0] c, input logic busy,
                                     input logic wt, input logic dn, input logic fl);
    return {run, we, a, d, c, busy, wt, dn, fl};
  endfunction

  function automatic vec_t mk(input logic st, input logic ab, input logic wi, input logic [7:0] revs,
                              input logic clr, input logic idx, input logic [7:0] dat,
                              input logic wr, input logic [22:0] e);
    vec_t v;
    v.st = st; v.ab = ab; v.wi = wi; v.revs = revs; v.clr = clr;
    v.idx = idx; v.dat = dat; v.wr = wr; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v);
    i_start = v.st; i_abort = v.ab; i_wait_index = v.wi; i_revs = v.revs;
    i_addr_clr = v.clr; i_index_in = v.idx; i_rd_data = v.dat; i_rd_write = v.wr;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input vec_t v, input string name);
    apply(v);
    cyc();
    check(name, 32'(obs), 32'(v.exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 8'd0, 0, 0, 8'h00, 0, '0);
    apply(idle);
    rst = 1'b1;

    // Basic capture with ABORT.
    tbl.push_back(mk(1, 0, 0, 8'd0, 0, 0, 8'h00, 0, ex(1, 0, 0, 8'h00, 0, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'h11, 1, ex(1, 1, 0, 8'h11, 1, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'h22, 1, ex(1, 1, 1, 8'h22, 2, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'h33, 1, ex(1, 1, 2, 8'h33, 3, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 0, 8'd0, 0, 0, 8'h00, 0, ex(0, 0, 2, 8'h33, 3, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'h00, 0, ex(0, 0, 2, 8'h33, 3, 0, 0, 0, 0)));
    // Index-armed, REVS=2, write on terminal edge and during FLUSH.
    tbl.push_back(mk(1, 0, 1, 8'd2, 0, 0, 8'h00, 0, ex(0, 0, 2, 8'h33, 3, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'h44, 1, ex(0, 0, 2, 8'h33, 3, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 1, 8'h00, 0, ex(1, 0, 2, 8'h33, 3, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'h00, 0, ex(1, 0, 2, 8'h33, 3, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 1, 8'h00, 0, ex(1, 0, 2, 8'h33, 3, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'h00, 0, ex(1, 0, 2, 8'h33, 3, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 1, 8'h55, 1, ex(0, 1, 3, 8'h55, 4, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'h66, 1, ex(0, 1, 4, 8'h66, 5, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'h00, 0, ex(0, 0, 4, 8'h66, 5, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'h00, 0, ex(0, 0, 4, 8'h66, 5, 0, 0, 1, 0)));
    // ADDR_CLR with START, then 20 writes into a 16-byte RAM.
    tbl.push_back(mk(1, 0, 0, 8'd0, 1, 0, 8'h00, 0, ex(1, 0, 4, 8'h66, 0, 1, 0, 0, 0)));
    for (int k = 0; k < 20; k++) begin
      logic [22:0] e;
      if (k < 15)       e = ex(1, 1, 4'(k), 8'(8'hA0 + k), 5'(k + 1), 1, 0, 0, 0);
      else if (k == 15) e = ex(0, 1, 4'd15, 8'hAF, 5'd16, 1, 0, 0, 1);
      else if (k < 18)  e = ex(0, 0, 4'd15, 8'hAF, 5'd16, 1, 0, 0, 1);
      else              e = ex(0, 0, 4'd15, 8'hAF, 5'd16, 0, 0, 1, 1);
      tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'(8'hA0 + k), 1, e));
    end
    // START while full goes straight to FLUSH.
    tbl.push_back(mk(1, 0, 0, 8'd0, 0, 0, 8'h00, 0, ex(0, 0, 15, 8'hAF, 16, 1, 0, 0, 1)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'h00, 0, ex(0, 0, 15, 8'hAF, 16, 1, 0, 0, 1)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'h00, 0, ex(0, 0, 15, 8'hAF, 16, 1, 0, 0, 1)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'h00, 0, ex(0, 0, 15, 8'hAF, 16, 0, 0, 1, 1)));
    tbl.push_back(mk(0, 0, 0, 8'd0, 1, 0, 8'h00, 0, ex(0, 0, 15, 8'hAF, 0, 0, 0, 1, 0)));

    repeat (2) @(negedge clk);
    check("reset_state", 32'({obs, o_no_index}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of CAPTURE.
    step(mk(1, 0, 0, 8'd0, 0, 0, 8'h00, 0, ex(1, 0, 15, 8'hAF, 0, 1, 0, 0, 0)), "rst_start");
    step(mk(0, 0, 0, 8'd0, 0, 0, 8'h77, 1, ex(1, 1, 0, 8'h77, 1, 1, 0, 0, 0)), "rst_write");
    #2 rst = 1'b1;
    #1 check("reset_async", 32'({obs, o_no_index}), 32'd0);
    @(negedge clk);
    apply(idle);
    rst = 1'b0;
    step(mk(1, 0, 0, 8'd0, 0, 0, 8'h00, 0, ex(1, 0, 0, 8'h00, 0, 1, 0, 0, 0)), "post_rst_start");
    step(mk(0, 0, 0, 8'd0, 0, 0, 8'h88, 1, ex(1, 1, 0, 8'h88, 1, 1, 0, 0, 0)), "post_rst_write");
    step(mk(0, 1, 0, 8'd0, 0, 0, 8'h00, 0, ex(0, 0, 0, 8'h88, 1, 0, 0, 0, 0)), "post_rst_abort");

    // ARM with no index pulse.
    step(mk(1, 0, 1, 8'd0, 0, 0, 8'h00, 0, ex(0, 0, 0, 8'h88, 1, 1, 1, 0, 0)), "arm_start");
`ifdef ACQ_TIMEOUT_EN
    for (int k = 1; k <= 10; k++) begin
      apply(idle);
      cyc();
      check($sformatf("tmo_waiting%0d", k), 32'(o_waiting), 32'(k < 10));
    end
    check("tmo_no_index", 32'(o_no_index), 32'd1);
    check("tmo_busy", 32'(o_busy), 32'd0);
    check("tmo_done", 32'(o_done), 32'd0);
    apply(mk(1, 0, 0, 8'd0, 0, 0, 8'h00, 0, '0));
    cyc();
    check("tmo_no_index_clr", 32'(o_no_index), 32'd0);
    check("tmo_restart_run", 32'(o_rd_run), 32'd1);
    apply(mk(0, 1, 0, 8'd0, 0, 0, 8'h00, 0, '0));
    cyc();
    check("tmo_abort_busy", 32'(o_busy), 32'd0);
`else
    for (int k = 1; k <= 100; k++) begin
      apply(idle);
      cyc();
      check($sformatf("arm_waiting%0d", k), 32'(o_waiting), 32'd1);
    end
    check("arm_no_index", 32'(o_no_index), 32'd0);
    check("arm_run", 32'(o_rd_run), 32'd0);
    apply(mk(0, 1, 0, 8'd0, 0, 0, 8'h00, 0, '0));
    cyc();
    check("arm_abort_busy", 32'(o_busy), 32'd0);
    check("arm_abort_done", 32'(o_done), 32'd0);
`endif
    apply(idle);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
